poly1305_mac_sequencer: RTL and testbench
=========================================

// Module: poly1305_mac_sequencer
// PURPOSE
//  Control FSM for the Poly1305 datapath. Accepts a one-time key (r,s) and 16-byte message blocks.
//  Per block, computes acc = ((acc + block) * r) mod p, p = 2^130-5, using the shared
//  mult_130x128_limb and reduce_mod_poly1305 units through start/done handshakes.
//  Then fully reduces acc and emits tag = (acc + s) mod 2^128. Sits between the ChaCha20 key/keystream
//  path and the multiplier/reducer pair inside the AEAD core.
// PARAMETERS
//  TIMEOUT   64   max cycles waited for mul_done or red_done before entering ERR
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high reset
//  key_load     in   1    pulse: latch r = key[127:0] clamped, s = key[255:128]; acc <= 0
//  key          in   256  one-time key, little-endian bytes (byte0 = bits 7:0)
//  key_ready    out  1    key_load is accepted this cycle
//  blk_valid    in   1    message block offered
//  blk_ready    out  1    block accepted when blk_valid & blk_ready
//  blk_data     in   128  block, little-endian; bytes >= blk_len are ignored
//  blk_len      in   5    valid bytes, 1..16; 0 is legal only with blk_last
//  blk_last     in   1    final block; finalize after it
//  mul_start    out  1    1-cycle start pulse to multiplier
//  mul_a        out  130  acc + padded block, folded to 130 bits
//  mul_b        out  128  clamped r
//  mul_done     in   1    multiplier result valid (consumed by reducer)
//  red_start    out  1    1-cycle start pulse to reducer
//  red_value    in   130  reducer output, < 2^130, not necessarily < p
//  red_done     in   1    red_value valid
//  tag          out  128  MAC tag, held until the next key_load
//  tag_valid    out  1    1-cycle pulse when tag is updated
//  busy         out  1    state not in {IDLE, READY, ERR}
//  err          out  1    sticky timeout flag
// BEHAVIOUR
//  Reset: state IDLE. acc, r, s, tag, mul_a, mul_b = 0. All pulses, busy, err and blk_ready = 0. key_ready = 1.
//  key_ready = 1 in IDLE, READY and ERR. key_load there clears acc and err, latches keys, and goes to READY.
//    key_load in other states is ignored.
//  Clamp: r = key[127:0] & 128'h0ffffffc0ffffffc0ffffffc0fffffff.
//  States: IDLE, READY, ADD, MUL_W, RED_W, FIN, TAG, ERR.
//  IDLE:  no key loaded. blk_ready = 0.
//  READY: blk_ready = 1. On handshake, latch the block. If blk_len = 0 (with blk_last), go to FIN.
//         Otherwise, go to ADD.
//  ADD (1 cycle): form padded block m = (blk_data masked to blk_len bytes) + 2^(8*blk_len).
//         Compute sum = acc + m (131 b). Fold: mul_a = sum[129:0] + 5*sum[130], which is < 2^130.
//         Drive mul_b = r and mul_start = 1 for this cycle only, then go to MUL_W.
//  MUL_W: on mul_done, pulse red_start for 1 cycle and go to RED_W.
//  RED_W: on red_done, acc <= red_value. If the latched last flag is set, go to FIN; else go to READY.
//  FIN (1 cycle): if acc >= p, acc <= acc - p.
//  TAG (1 cycle): tag <= acc[127:0] + s[127:0] (mod 2^128). Pulse tag_valid.
//         Clear r, s, acc and go to IDLE, so a new key is required.
//  Timeout: a wait counter clears on each start pulse and increments in MUL_W/RED_W.
//    When it reaches TIMEOUT without a done, go to ERR and set err = 1.
//  ERR: blk_ready = 0 and no start pulses. Left only via key_load or reset.
//  A done arriving in a state other than its wait state is ignored.
//  mul_done and red_done in the same cycle: only the done matching the current state acts.
//  blk_valid while not READY: blk_ready = 0 and nothing is consumed; the producer holds the block.
//  Reset mid-operation: returns to IDLE next cycle. The key is lost and start pulses stop immediately.
//  Latency per block: 1 (accept) + 1 (ADD) + multiplier + reducer latency.
//    Tag appears 2 cycles after the last red_done.
// TESTING
//  (Bench uses behavioral mul/red models with random 1..10 cycle latency.)
//  RFC 8439 2.5.2: key r=85d6be7857556d337f4452fe42d506a8, s=0103808afb0db2fd4abff6af4149f51b.
//    Message "Cryptographic Forum Research Group" (34 B, lens 16,16,2, last on third block)
//    -> tag a8061dc130513 6c6c22b8baf0c0127a9 (bytes LE).
//  Key r=0, s=0, one block len=0 with last -> tag = 0, tag_valid 2 cycles after handshake, no mul_start.
//  Force acc = p+3 before FIN (r=1 path, crafted block) -> FIN subtracts p.
//    With s=0, tag = 3.
//  Hold mul_done low for TIMEOUT cycles -> err = 1, state ERR, blk_ready = 0.
//    Then key_load -> err = 0, READY.
//  Assert blk_valid continuously with 4 blocks -> exactly one mul_start per block.
//    blk_ready is low from accept until red_done.
//  Assert reset while in MUL_W -> next cycle busy = 0, key_ready = 1, blk_ready = 0.
//    A late mul_done produces no red_start.

Source files
------------

// File: rtl/poly1305_mac_sequencer_if.sv
// poly1305_mac_sequencer_if: key, block, multiplier/reducer and tag signals of the Poly1305 sequencer
interface poly1305_mac_sequencer_if;
  logic         key_load;
  logic [255:0] key;
  logic         key_ready;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [4:0]   blk_len;
  logic         blk_last;
  logic         mul_start;
  logic [129:0] mul_a;
  logic [127:0] mul_b;
  logic         mul_done;
  logic         red_start;
  logic [129:0] red_value;
  logic         red_done;
  logic [127:0] tag;
  logic         tag_valid;
  logic         busy;
  logic         err;
  modport slave (
    input  key_load, key, blk_valid, blk_data, blk_len, blk_last, mul_done, red_value, red_done,
    output key_ready, blk_ready, mul_start, mul_a, mul_b, red_start, tag, tag_valid, busy, err
  );
  modport master (
    output key_load, key, blk_valid, blk_data, blk_len, blk_last, mul_done, red_value, red_done,
    input  key_ready, blk_ready, mul_start, mul_a, mul_b, red_start, tag, tag_valid, busy, err
  );
endinterface

// File: rtl/poly1305_mac_sequencer.sv
// poly1305_mac_sequencer: Poly1305 control FSM sequencing block absorb, multiply/reduce handshakes and tag output
module poly1305_mac_sequencer #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  poly1305_mac_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READY, ADD, MUL_W, RED_W, FIN, TAG, ERR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [129:0] P = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  state_t state_q, state_d;
  logic [129:0] acc_q, acc_d, mul_a_q, mul_a_d, folded;
  logic [127:0] r_q, r_d, s_q, s_d, tag_q, tag_d, mul_b_q, mul_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, err_q, err_d, red_start_q, red_start_d, tag_valid_q, tag_valid_d;
  logic key_ready_q, blk_ready_q, mul_start_q, busy_q, timed_out;
  logic [128:0] pad, m;
  logic [130:0] sum;
  always_comb begin
    pad = 129'd1 << {bus.blk_len, 3'b000};
    m = ({1'b0, bus.blk_data} & (pad - 129'd1)) | pad;
    sum = {1'b0, acc_q} + {2'b00, m};
    folded = sum[129:0] + (sum[130] ? 130'd5 : 130'd0);
    timed_out = cnt_q == CW'(TIMEOUT - 1);
    state_d = state_q;
    acc_d = acc_q;
    r_d = r_q;
    s_d = s_q;
    tag_d = tag_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    last_d = last_q;
    cnt_d = cnt_q;
    err_d = err_q;
    red_start_d = 1'b0;
    tag_valid_d = 1'b0;
    if (bus.key_load && key_ready_q) begin
      r_d = bus.key[127:0] & CLAMP;
      s_d = bus.key[255:128];
      acc_d = '0;
      err_d = 1'b0;
      state_d = READY;
    end else begin
      case (state_q)
        READY: if (bus.blk_valid) begin
          last_d = bus.blk_last;
          mul_a_d = bus.blk_len == 5'd0 ? mul_a_q : folded;
          mul_b_d = bus.blk_len == 5'd0 ? mul_b_q : r_q;
          state_d = bus.blk_len == 5'd0 ? FIN : ADD;
        end
        ADD: begin
          cnt_d = '0;
          state_d = MUL_W;
        end
        MUL_W: if (bus.mul_done) begin
          red_start_d = 1'b1;
          cnt_d = '0;
          state_d = RED_W;
        end else begin
          cnt_d = cnt_q + 1'b1;
          err_d = err_q | timed_out;
          state_d = timed_out ? ERR : MUL_W;
        end
        RED_W: if (bus.red_done) begin
          acc_d = bus.red_value;
          state_d = last_q ? FIN : READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
          err_d = err_q | timed_out;
          state_d = timed_out ? ERR : RED_W;
        end
        FIN: begin
          acc_d = acc_q >= P ? acc_q - P : acc_q;
          state_d = TAG;
        end
        TAG: begin
          tag_d = acc_q[127:0] + s_q;
          tag_valid_d = 1'b1;
          acc_d = '0;
          r_d = '0;
          s_d = '0;
          state_d = IDLE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      r_q <= '0;
      s_q <= '0;
      tag_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      red_start_q <= 1'b0;
      tag_valid_q <= 1'b0;
      key_ready_q <= 1'b1;
      blk_ready_q <= 1'b0;
      mul_start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      r_q <= r_d;
      s_q <= s_d;
      tag_q <= tag_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      red_start_q <= red_start_d;
      tag_valid_q <= tag_valid_d;
      key_ready_q <= state_d inside {IDLE, READY, ERR};
      blk_ready_q <= state_d == READY;
      mul_start_q <= state_d == ADD;
      busy_q <= !(state_d inside {IDLE, READY, ERR});
    end
  end
  assign bus.key_ready = key_ready_q;
  assign bus.blk_ready = blk_ready_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_a = mul_a_q;
  assign bus.mul_b = mul_b_q;
  assign bus.red_start = red_start_q;
  assign bus.tag = tag_q;
  assign bus.tag_valid = tag_valid_q;
  assign bus.busy = busy_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_poly1305_mac_sequencer.sv
// tb_poly1305_mac_sequencer: randomized self-checking bench against a big-integer Poly1305 reference model
module tb_poly1305_mac_sequencer;
  localparam int TIMEOUT = 64;
  localparam logic [259:0] P260 = 260'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [129:0] P130 = 130'h3_ffffffff_ffffffff_ffffffff_fffffffb;
  localparam logic [127:0] CLAMP = 128'h0ffffffc_0ffffffc_0ffffffc_0fffffff;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  poly1305_mac_sequencer_if bus();
  poly1305_mac_sequencer #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  int checks = 0;
  int failures = 0;
  logic mul_done_m = 1'b0, red_done_m = 1'b0, spur_mul = 1'b0, spur_red = 1'b0;
  logic mul_hang = 1'b0, red_force = 1'b0;
  int mul_lat_fix = 0;
  logic [129:0] red_value_m = '0, red_force_val = '0;
  logic [259:0] prod = '0;
  logic [127:0] last_b = '0;
  int n_mul = 0, n_red = 0, ready_viol = 0;
  logic inflight = 1'b0;
  logic [127:0] q_data[$];
  int q_len[$];
  assign bus.mul_done = mul_done_m | spur_mul;
  assign bus.red_done = red_done_m | spur_red;
  assign bus.red_value = red_value_m;
  initial forever begin
    @(negedge clk);
    if (bus.mul_start && !mul_hang) begin
      prod = 260'(bus.mul_a) * 260'(bus.mul_b);
      last_b = bus.mul_b;
      repeat (mul_lat_fix != 0 ? mul_lat_fix : int'($urandom_range(1, 10))) @(negedge clk);
      mul_done_m = 1'b1;
      @(negedge clk);
      mul_done_m = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (bus.red_start) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      red_value_m = red_force ? red_force_val : 130'(prod % P260);
      red_done_m = 1'b1;
      @(negedge clk);
      red_done_m = 1'b0;
    end
  end
  always @(posedge clk) begin
    if (bus.mul_start) n_mul <= n_mul + 1;
    if (bus.red_start) n_red <= n_red + 1;
    if (inflight && bus.blk_ready) ready_viol <= ready_viol + 1;
    inflight <= (reset || (bus.key_load && bus.key_ready)) ? 1'b0 :
                (bus.blk_valid && bus.blk_ready) ? 1'b1 : bus.red_done ? 1'b0 : inflight;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end
  function automatic logic [127:0] model_tag(input logic [255:0] k);
    logic [259:0] acc, m, r;
    acc = '0;
    r = 260'(k[127:0] & CLAMP);
    foreach (q_len[i]) begin
      if (q_len[i] != 0) begin
        m = '0;
        for (int j = 0; j < q_len[i]; j++) m[8*j+:8] = q_data[i][8*j+:8];
        m[8*q_len[i]] = 1'b1;
        acc = ((acc + m) * r) % P260;
      end
    end
    return 128'(acc + 260'(k[255:128]));
  endfunction
  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j+:32] = $urandom();
    return v;
  endfunction
  task automatic load_key(input logic [255:0] k);
    bus.key = k;
    bus.key_load = 1'b1;
    @(negedge clk);
    bus.key_load = 1'b0;
  endtask
  task automatic send_block(input logic [127:0] d, input int len, input logic last);
    int i;
    bus.blk_data = d;
    bus.blk_len = 5'(len);
    bus.blk_last = last;
    bus.blk_valid = 1'b1;
    for (i = 0; i < 500 && !bus.blk_ready; i++) @(negedge clk);
    checks++;
    if (!bus.blk_ready) begin
      failures++;
      $display("FAIL send_block: blk_ready=%0b required 1 within 500 cycles", bus.blk_ready);
    end
    @(negedge clk);
  endtask
  task automatic wait_tag(output logic [127:0] t, output int cyc);
    bus.blk_valid = 1'b0;
    cyc = 0;
    while (!bus.tag_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!bus.tag_valid) begin
      failures++;
      $display("FAIL wait_tag: tag_valid=0 required 1 within 3000 cycles");
    end
    t = bus.tag;
    @(negedge clk);
  endtask
  task automatic send_msg(output logic [127:0] t, output int cyc);
    foreach (q_len[i]) send_block(q_data[i], q_len[i], i == q_len.size() - 1);
    wait_tag(t, cyc);
  endtask
  task automatic run_msg(input logic [255:0] k, output logic [127:0] t, output int cyc);
    load_key(k);
    send_msg(t, cyc);
  endtask
  task automatic fill_random(input int nb, input int min_last);
    q_data.delete();
    q_len.delete();
    for (int i = 0; i < nb; i++) begin
      q_data.push_back(rand256()[127:0]);
      q_len.push_back(i == nb - 1 ? int'($urandom_range(min_last, 16)) : int'($urandom_range(1, 16)));
    end
  endtask
  task automatic test_reset();
    bus.key_load = 1'b0;
    bus.key = '0;
    bus.blk_valid = 1'b0;
    bus.blk_data = '0;
    bus.blk_len = '0;
    bus.blk_last = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.err, bus.tag_valid, bus.mul_start, bus.red_start, bus.blk_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: busy/err/tv/ms/rs/br=%b required 000000",
               {bus.busy, bus.err, bus.tag_valid, bus.mul_start, bus.red_start, bus.blk_ready});
    end
    checks++;
    if (bus.key_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_key_ready: got %b required 1", bus.key_ready);
    end
    checks++;
    if (bus.tag !== 128'd0) begin
      failures++;
      $display("FAIL reset_tag: got %h required 0", bus.tag);
    end
    checks++;
    if (bus.mul_a !== 130'd0 || bus.mul_b !== 128'd0) begin
      failures++;
      $display("FAIL reset_mul_ops: mul_a=%h mul_b=%h required 0", bus.mul_a, bus.mul_b);
    end
  endtask
  task automatic test_rfc();
    logic [127:0] rbe, sbe, tbe, b0, b1, rr, ss, texp, d0, d1, t;
    logic [15:0] u, ur;
    int cyc;
    rbe = 128'h85d6be7857556d337f4452fe42d506a8;
    sbe = 128'h0103808afb0db2fd4abff6af4149f51b;
    tbe = 128'ha8061dc1305136c6c22b8baf0c0127a9;
    rr = {<<8{rbe}};
    ss = {<<8{sbe}};
    texp = {<<8{tbe}};
    b0 = "Cryptographic Fo";
    b1 = "rum Research Gro";
    u = "up";
    d0 = {<<8{b0}};
    d1 = {<<8{b1}};
    ur = {<<8{u}};
    q_data = '{d0, d1, {112'd0, ur}};
    q_len = '{16, 16, 2};
    run_msg({ss, rr}, t, cyc);
    checks++;
    if (t !== texp) begin
      failures++;
      $display("FAIL rfc_tag: got %h required %h", t, texp);
    end
    checks++;
    if (t !== model_tag({ss, rr})) begin
      failures++;
      $display("FAIL rfc_model: got %h required %h", t, model_tag({ss, rr}));
    end
    checks++;
    if (last_b !== (rr & CLAMP)) begin
      failures++;
      $display("FAIL rfc_mul_b: got %h required %h", last_b, rr & CLAMP);
    end
  endtask
  task automatic test_empty();
    logic [127:0] t;
    int cyc, base;
    q_data = '{128'h0};
    q_len = '{0};
    base = n_mul;
    run_msg('0, t, cyc);
    checks++;
    if (t !== 128'd0) begin
      failures++;
      $display("FAIL empty_tag: got %h required 0", t);
    end
    checks++;
    if (cyc != 2) begin
      failures++;
      $display("FAIL empty_latency: got %0d cycles required 2", cyc);
    end
    checks++;
    if (n_mul - base != 0) begin
      failures++;
      $display("FAIL empty_mul_start: got %0d pulses required 0", n_mul - base);
    end
  endtask
  task automatic test_random();
    logic [255:0] k;
    logic [127:0] t;
    int cyc;
    for (int n = 0; n < 6; n++) begin
      k = rand256();
      fill_random(int'($urandom_range(1, 4)), 0);
      run_msg(k, t, cyc);
      checks++;
      if (t !== model_tag(k)) begin
        failures++;
        $display("FAIL random_tag[%0d]: got %h required %h", n, t, model_tag(k));
      end
    end
  endtask
  task automatic test_fin_reduce();
    logic [127:0] t;
    int cyc;
    red_force = 1'b1;
    red_force_val = P130 + 130'd3;
    fill_random(1, 16);
    run_msg({128'd0, 128'd1}, t, cyc);
    red_force = 1'b0;
    checks++;
    if (t !== 128'd3) begin
      failures++;
      $display("FAIL fin_reduce: got %h required 3", t);
    end
  endtask
  task automatic test_back_to_back();
    logic [255:0] k;
    logic [127:0] t;
    int cyc, bm, br, bv;
    k = rand256();
    fill_random(4, 1);
    bm = n_mul;
    br = n_red;
    bv = ready_viol;
    run_msg(k, t, cyc);
    checks++;
    if (n_mul - bm != 4 || n_red - br != 4) begin
      failures++;
      $display("FAIL b2b_starts: mul=%0d red=%0d required 4 each", n_mul - bm, n_red - br);
    end
    checks++;
    if (ready_viol - bv != 0) begin
      failures++;
      $display("FAIL b2b_ready_low: got %0d early-ready cycles required 0", ready_viol - bv);
    end
    checks++;
    if (t !== model_tag(k)) begin
      failures++;
      $display("FAIL b2b_tag: got %h required %h", t, model_tag(k));
    end
  endtask
  task automatic test_spurious_done();
    logic [255:0] k;
    logic [127:0] t;
    int cyc, bm, br;
    k = rand256();
    fill_random(2, 1);
    load_key(k);
    bm = n_mul;
    br = n_red;
    spur_mul = 1'b1;
    spur_red = 1'b1;
    @(negedge clk);
    spur_mul = 1'b0;
    spur_red = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.blk_ready !== 1'b1 || n_mul != bm || n_red != br) begin
      failures++;
      $display("FAIL spurious_done: busy=%b blk_ready=%b starts=%0d required 0 1 0",
               bus.busy, bus.blk_ready, n_mul - bm + n_red - br);
    end
    send_msg(t, cyc);
    checks++;
    if (t !== model_tag(k)) begin
      failures++;
      $display("FAIL spurious_tag: got %h required %h", t, model_tag(k));
    end
  endtask
  task automatic test_timeout();
    int cyc, bm;
    mul_hang = 1'b1;
    load_key(rand256());
    bm = n_mul;
    send_block(rand256()[127:0], 16, 1'b0);
    bus.blk_valid = 1'b0;
    cyc = 0;
    while (!bus.err && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.err !== 1'b1 || cyc < TIMEOUT || cyc > TIMEOUT + 2) begin
      failures++;
      $display("FAIL timeout_err: err=%b after %0d cycles required 1 after %0d..%0d", bus.err, cyc, TIMEOUT, TIMEOUT + 2);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.blk_ready, bus.key_ready, bus.err} !== 4'b0011) begin
      failures++;
      $display("FAIL timeout_state: busy/br/kr/err=%b required 0011", {bus.busy, bus.blk_ready, bus.key_ready, bus.err});
    end
    checks++;
    if (n_mul - bm != 1) begin
      failures++;
      $display("FAIL timeout_starts: got %0d mul_start pulses required 1", n_mul - bm);
    end
    mul_hang = 1'b0;
    load_key(rand256());
    checks++;
    if (bus.err !== 1'b0 || bus.blk_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_recover: err=%b blk_ready=%b required 0 1", bus.err, bus.blk_ready);
    end
  endtask
  task automatic test_reset_mid();
    int br;
    mul_lat_fix = 8;
    load_key(rand256());
    send_block(rand256()[127:0], 16, 1'b1);
    @(negedge clk);
    bus.blk_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.key_ready, bus.blk_ready, bus.mul_start} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_mid: busy/kr/br/ms=%b required 0100", {bus.busy, bus.key_ready, bus.blk_ready, bus.mul_start});
    end
    reset = 1'b0;
    br = n_red;
    repeat (20) @(negedge clk);
    mul_lat_fix = 0;
    checks++;
    if (n_red != br || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_late_done: red_start=%0d busy=%b required 0 0", n_red - br, bus.busy);
    end
  endtask
  initial begin
    test_reset();
    test_rfc();
    test_empty();
    test_random();
    test_fin_reduce();
    test_back_to_back();
    test_spurious_done();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
